// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared constants and state encoding for the run/halt/step
// controller.
//   ADDR_W   - width of the fetch PC and breakpoint address
//   CNT_W    - width of the advanced-cycle counter
//   state_t  - controller state, 2-bit encoding RUN=0, HALT=1, STEP=2
//   state_advances() - pipeline-enable decode for a given state
package step_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Pipeline advances in RUN and in the single STEP cycle, never in HALT.
  function automatic logic state_advances(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: 1-bit two-flop synchronizer for asynchronous operator levels.
// Ports:
//   clock - sampling clock (rising edge)
//   reset - synchronous active-high reset, clears both flops
//   d     - asynchronous input level
//   q     - synchronized level, two clock edges behind d
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: run/halt/single-step controller for a downstream pipeline.
// Operator levels "change" and "step" are synchronized and edge-detected;
// a change edge toggles RUN/HALT, a step edge in HALT grants one pipeline
// cycle, and an armed breakpoint matching the fetch PC halts a running
// pipeline.
// Ports:
//   clock     - single clock, rising edge
//   reset     - synchronous active-high reset
//   change    - operator level, rising edge toggles run/halt
//   step      - operator level, rising edge in HALT requests one advance
//   pc        - fetch-stage PC of the downstream pipeline
//   bp_addr   - breakpoint address (full-width compare)
//   bp_valid  - breakpoint armed
//   advance   - pipeline enable, decoded from the state register
//   halted    - high only in HALT
//   cycle_cnt - count of advanced cycles
// Build option: define STEP_CTRL_CYCLE_CNT_EN to implement the advanced-cycle
// counter; without it cycle_cnt is tied to zero and no counter is built.
module step_ctrl
  import step_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              change,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  output logic              advance,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt
);

  logic   change_sync;
  logic   step_sync;
  logic   change_prev;
  logic   step_prev;
  logic   change_edge;
  logic   step_edge;
  logic   bp_hit;
  logic   guard_q;
  logic   guard_d;
  state_t state_q;
  state_t state_d;

  // Synchronize the asynchronous operator levels.
  sync2 u_change_sync (
    .clock (clock),
    .reset (reset),
    .d     (change),
    .q     (change_sync)
  );

  sync2 u_step_sync (
    .clock (clock),
    .reset (reset),
    .d     (step),
    .q     (step_sync)
  );

  // One registered history bit per input for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      change_prev <= 1'b0;
      step_prev   <= 1'b0;
    end else begin
      change_prev <= change_sync;
      step_prev   <= step_sync;
    end
  end

  assign change_edge = change_sync & ~change_prev;
  assign step_edge   = step_sync & ~step_prev;

  // Breakpoint is ignored on the first RUN cycle after a resume so the
  // pipeline can move off the instruction it stopped at.
  assign bp_hit = bp_valid && (pc == bp_addr) && advance && !guard_q;

  // State register and resume guard.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  // Next-state logic; edges not consumed by the current state are dropped.
  always_comb begin
    state_d = state_q;
    guard_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (change_edge || bp_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // change has priority over a coincident step edge
        if (change_edge) begin
          state_d = ST_RUN;
          guard_d = 1'b1;
        end else if (step_edge) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign advance = state_advances(state_q);
  assign halted  = (state_q == ST_HALT);

`ifdef STEP_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts every edge on which the pipeline advanced; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed scoreboard bench for step_ctrl. Stimulus pushes the
// hand-derived expected outputs for a given cycle; a negedge monitor pops and
// compares them against the DUT.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              change;
  logic              step;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_valid;
  logic              advance;
  logic              halted;
  logic [CNT_W-1:0]  cycle_cnt;

  step_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .change    (change),
    .step      (step),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .advance   (advance),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned      cyc;
    string            name;
    logic             adv;
    logic             hlt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic             exp_adv;
  logic             exp_halt;
  logic [CNT_W-1:0] exp_cnt;

  function automatic logic [CNT_W-1:0] cnt_view(input logic [CNT_W-1:0] c);
`ifdef STEP_CTRL_CYCLE_CNT_EN
    return c;
`else
    return (c & 32'd0);
`endif
  endfunction

  task automatic expect_now(input string name);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.adv  = exp_adv;
    e.hlt  = exp_halt;
    e.cnt  = cnt_view(exp_cnt);
    sbq.push_back(e);
  endtask

  // One clock edge; the expected counter follows the expected enable.
  task automatic tick();
    @(posedge clock);
    if (exp_adv) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic go_halt();
    exp_adv  = 1'b0;
    exp_halt = 1'b1;
  endtask

  task automatic go_run();
    exp_adv  = 1'b1;
    exp_halt = 1'b0;
  endtask

  // Monitor: compare every due expectation against the DUT outputs.
  always @(negedge clock) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (advance !== e.adv || halted !== e.hlt || cycle_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got advance=%0b halted=%0b cycle_cnt=%0d, want advance=%0b halted=%0b cycle_cnt=%0d",
                 e.name, advance, halted, cycle_cnt, e.adv, e.hlt, e.cnt);
      end
    end
  end

  // change held 3 cycles: state flips on the 3rd edge after the rise.
  task automatic do_change(input string tag, input logic to_halt);
    change = 1'b1;
    tick();
    tick();
    expect_now({tag, "_pre"});
    tick();
    if (to_halt) go_halt(); else go_run();
    expect_now({tag, "_post"});
    change = 1'b0;
    tick();
    tick();
    tick();
    expect_now({tag, "_settled"});
  endtask

  // step held 3 cycles in HALT: exactly one advancing cycle.
  task automatic do_step(input string tag);
    step = 1'b1;
    tick();
    tick();
    expect_now({tag, "_pre"});
    tick();
    go_run();
    expect_now({tag, "_step"});
    step = 1'b0;
    tick();
    go_halt();
    expect_now({tag, "_back"});
    tick();
    tick();
    tick();
    expect_now({tag, "_settled"});
  endtask

  initial begin
    reset    = 1'b1;
    change   = 1'b0;
    step     = 1'b0;
    pc       = 32'h0;
    bp_addr  = 32'h0;
    bp_valid = 1'b0;
    go_run();
    exp_cnt  = 32'd0;

    // Reset for two cycles, then free-running count.
    tick();
    tick();
    reset   = 1'b0;
    exp_cnt = 32'd0;
    expect_now("reset");
    tick(); expect_now("run_cnt1");
    tick(); expect_now("run_cnt2");
    tick(); expect_now("run_cnt3");

    // Halt, then two single steps.
    do_change("halt1", 1'b1);
    do_step("step1");
    do_step("step2");
    do_change("resume1", 1'b0);

    // Breakpoint: upper-bit mismatch must not hit, then PC walk to 0x10.
    bp_addr  = 32'h0000_0010;
    bp_valid = 1'b1;
    pc       = 32'h0001_0010;
    tick(); expect_now("bp_fullwidth");
    pc = 32'h0;
    tick(); pc = 32'h4;
    tick(); pc = 32'h8;
    tick(); pc = 32'hC;
    tick(); pc = 32'h10;
    expect_now("bp_pre");
    tick();
    go_halt();
    expect_now("bp_halt");
    tick(); expect_now("bp_hold");

    // Resume at the breakpoint PC; guarded cycle must not re-halt.
    change = 1'b1;
    tick();
    tick();
    expect_now("bp_resume_pre");
    tick();
    go_run();
    expect_now("bp_resume_guard");
    tick();
    pc = 32'h14;
    expect_now("bp_no_rehalt");
    change = 1'b0;
    tick();
    tick();
    tick();
    expect_now("bp_pc14");
    bp_valid = 1'b0;

    // Coincident change and step in HALT: change wins, no STEP cycle.
    do_change("halt2", 1'b1);
    change = 1'b1;
    step   = 1'b1;
    tick();
    tick();
    expect_now("sim_pre");
    tick();
    go_run();
    expect_now("sim_run");
    tick(); expect_now("sim_no_step");
    change = 1'b0;
    step   = 1'b0;
    tick();
    tick();
    tick();
    expect_now("sim_settled");

    // Step edge in RUN is ignored.
    step = 1'b1;
    tick();
    tick();
    tick();
    expect_now("run_step_ignored");
    step = 1'b0;
    tick();
    tick();
    tick();
    expect_now("run_step_settled");

    // Reset during STEP returns to RUN with a cleared counter.
    do_change("halt3", 1'b1);
    step = 1'b1;
    tick();
    tick();
    tick();
    go_run();
    expect_now("rst_in_step");
    reset = 1'b1;
    tick();
    exp_cnt = 32'd0;
    expect_now("rst_step_run");
    reset = 1'b0;
    step  = 1'b0;
    tick(); expect_now("rst_cnt1");

    // A 1 ns change pulse between edges is never sampled.
    #2 change = 1'b1;
    #1 change = 1'b0;
    tick();
    tick();
    tick();
    tick();
    expect_now("pulse_ignored");

    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
